// File: rtl/aes_key_pkg.sv
// Shared types and helpers for the AES key-schedule engine: FSM states,
// key-length geometry and the round-constant xtime step.
package aes_key_pkg;

    typedef enum logic [1:0] {IDLE, EMIT_KEY, EXPAND, DONE} state_e;

    typedef struct packed {
        int nk;
        int nr;
        int nwords;
    } key_cfg_t;

    localparam logic [7:0] RCON_INIT = 8'h01;
    localparam logic [7:0] RCON_POLY = 8'h1B;

    function automatic key_cfg_t key_cfg(input int key_len);
        key_cfg_t c;
        c.nk     = key_len / 32;
        c.nr     = c.nk + 6;
        c.nwords = 4 * (c.nr + 1);
        return c;
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] rc);
        return {rc[6:0], 1'b0} ^ (rc[7] ? RCON_POLY : 8'h00);
    endfunction

endpackage

// File: rtl/aes_key_expander_if.sv
// Key-load and schedule-word stream between the key register file, the
// expander (master) and the round-key store (slave).
interface aes_key_expander_if #(
    parameter int KEY_LEN = 128
);
    logic               start;
    logic [KEY_LEN-1:0] key_in;
    logic               word_valid;
    logic               word_ready;
    logic [31:0]        word_out;
    logic [5:0]         word_idx;
    logic               busy;
    logic               done;

    modport master (
        input  start, key_in, word_ready,
        output word_valid, word_out, word_idx, busy, done
    );

    modport slave (
        output start, key_in, word_ready,
        input  word_valid, word_out, word_idx, busy, done
    );
endinterface

// File: rtl/aes_sbox.sv
// Combinational AES forward S-box, one byte in, one byte out.
module aes_sbox (
    input  logic [7:0] in_i,
    output logic [7:0] out_o
);
    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    assign out_o = SBOX[in_i];
endmodule

// File: rtl/aes_key_expander.sv
// Sequential AES-128/192/256 key schedule: streams w[0]..w[NWORDS-1], one word
// per valid/ready transfer, deriving round constants with xtime.
module aes_key_expander
    import aes_key_pkg::*;
#(
    parameter int KEY_LEN = 128
) (
    input  logic clk,
    input  logic rst,
    aes_key_expander_if.master bus
);
    localparam key_cfg_t CFG    = key_cfg(KEY_LEN);
    localparam int       NK     = CFG.nk;
    localparam int       NWORDS = CFG.nwords;
    localparam int       IW     = $clog2(NK);

    if (KEY_LEN != 128 && KEY_LEN != 192 && KEY_LEN != 256) begin : g_bad_key_len
        $error("aes_key_expander: KEY_LEN must be 128, 192 or 256");
    end

    state_e      state_q, state_d;
    logic [31:0] win_q [NK];
    logic [31:0] win_d [NK];
    logic [31:0] out_q, out_d;
    logic [5:0]  idx_q, idx_d;
    logic [7:0]  rc_q, rc_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        valid_q, valid_d;

    logic [31:0] temp, rot, sub_in, sub_out, mix, w_new;
    logic [IW-1:0] nxt;
    logic        xfer;

    for (genvar b = 0; b < 4; b++) begin : g_subword
        aes_sbox u_sbox (.in_i(sub_in[8*b +: 8]), .out_o(sub_out[8*b +: 8]));
    end

    // Window holds the last Nk words, oldest at [0]; cnt_q is (idx+1) mod Nk.
    always_comb begin
        temp   = win_q[NK-1];
        rot    = {temp[23:0], temp[31:24]};
        sub_in = (cnt_q == 3'd0) ? rot : temp;
        mix    = temp;
        if (cnt_q == 3'd0)
            mix = sub_out ^ {rc_q, 24'h0};
        else if (NK == 8 && cnt_q == 3'd4)
            mix = sub_out;
        w_new  = win_q[0] ^ mix;
    end

    always_comb begin
        state_d = state_q;
        win_d   = win_q;
        out_d   = out_q;
        idx_d   = idx_q;
        rc_d    = rc_q;
        cnt_d   = cnt_q;
        valid_d = valid_q;
        xfer    = valid_q & bus.word_ready;
        nxt     = idx_q[IW-1:0] + IW'(1);
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    for (int k = 0; k < NK; k++)
                        win_d[k] = bus.key_in[KEY_LEN-1-32*k -: 32];
                    out_d   = bus.key_in[KEY_LEN-1 -: 32];
                    idx_d   = 6'd0;
                    rc_d    = RCON_INIT;
                    cnt_d   = 3'd1;
                    valid_d = 1'b1;
                    state_d = EMIT_KEY;
                end
            end
            EMIT_KEY, EXPAND: begin
                if (xfer) begin
                    if (idx_q == 6'(NWORDS-1)) begin
                        valid_d = 1'b0;
                        state_d = DONE;
                    end else begin
                        idx_d = idx_q + 6'd1;
                        cnt_d = (cnt_q == 3'(NK-1)) ? 3'd0 : cnt_q + 3'd1;
                        if (state_q == EMIT_KEY && idx_q != 6'(NK-1)) begin
                            out_d = win_q[nxt];
                        end else begin
                            out_d = w_new;
                            for (int k = 0; k < NK-1; k++)
                                win_d[k] = win_q[k+1];
                            win_d[NK-1] = w_new;
                            if (cnt_q == 3'd0)
                                rc_d = xtime(rc_q);
                            state_d = EXPAND;
                        end
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            out_q   <= 32'h0;
            idx_q   <= 6'd0;
            rc_q    <= RCON_INIT;
            cnt_q   <= 3'd0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            idx_q   <= idx_d;
            rc_q    <= rc_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
        end
    end

    // Key window is pure data and is always reloaded on start.
    always_ff @(posedge clk) begin
        win_q <= win_d;
    end

    assign bus.word_valid = valid_q;
    assign bus.word_out   = out_q;
    assign bus.word_idx   = idx_q;
    assign bus.busy       = (state_q == EMIT_KEY) || (state_q == EXPAND);
    assign bus.done       = (state_q == DONE);
endmodule

// File: tb/tb_aes_key_expander.sv
// Directed bench for aes_key_expander: FIPS-197 key vectors for all three key
// sizes, backpressure, mid-run reset and start-while-busy.
module tb_aes_key_expander;
    localparam logic [127:0] K128 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] KALT = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [191:0] K192 = 192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b;
    localparam logic [255:0] K256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

    logic         clk = 1'b0;
    logic         rst;
    logic [2:0]   st;
    logic         rdy;
    logic [1:0]   sel;
    logic [127:0] key_a;

    int n_chk = 0;
    int n_fail = 0;

    aes_key_expander_if #(.KEY_LEN(128)) ifa ();
    aes_key_expander_if #(.KEY_LEN(192)) ifb ();
    aes_key_expander_if #(.KEY_LEN(256)) ifc ();

    aes_key_expander #(.KEY_LEN(128)) dut_a (.clk(clk), .rst(rst), .bus(ifa.master));
    aes_key_expander #(.KEY_LEN(192)) dut_b (.clk(clk), .rst(rst), .bus(ifb.master));
    aes_key_expander #(.KEY_LEN(256)) dut_c (.clk(clk), .rst(rst), .bus(ifc.master));

    assign ifa.start = st[0];
    assign ifb.start = st[1];
    assign ifc.start = st[2];
    assign ifa.key_in = key_a;
    assign ifb.key_in = K192;
    assign ifc.key_in = K256;
    assign ifa.word_ready = rdy;
    assign ifb.word_ready = rdy;
    assign ifc.word_ready = rdy;

    always #5 clk = ~clk;

    logic        m_valid, m_busy, m_done;
    logic [31:0] m_out;
    logic [5:0]  m_idx;

    always_comb begin
        m_valid = ifa.word_valid;
        m_out   = ifa.word_out;
        m_idx   = ifa.word_idx;
        m_busy  = ifa.busy;
        m_done  = ifa.done;
        if (sel == 2'd1) begin
            m_valid = ifb.word_valid;
            m_out   = ifb.word_out;
            m_idx   = ifb.word_idx;
            m_busy  = ifb.busy;
            m_done  = ifb.done;
        end else if (sel == 2'd2) begin
            m_valid = ifc.word_valid;
            m_out   = ifc.word_out;
            m_idx   = ifc.word_idx;
            m_busy  = ifc.busy;
            m_done  = ifc.done;
        end
    end

    logic [31:0] lg [64];
    logic [31:0] ref_lg [64];
    int          nxf = 0;
    int          ndone = 0;
    int          viol = 0;
    logic        stall_q = 1'b0;
    logic [31:0] prev_out = 32'h0;
    logic [5:0]  prev_idx = 6'd0;

    // Transfer log plus hold-under-backpressure monitor on the selected DUT.
    always @(posedge clk) begin
        if (m_valid && rdy) begin
            lg[m_idx] <= m_out;
            nxf <= nxf + 1;
        end
        if (m_done) ndone <= ndone + 1;
        stall_q  <= m_valid && !rdy;
        prev_out <= m_out;
        prev_idx <= m_idx;
        if (stall_q && (!m_valid || m_out != prev_out || m_idx != prev_idx))
            viol <= viol + 1;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic run(input bit rnd, input bit poke, output int edges, output int vcnt,
                       output int early);
        int n;
        vcnt  = 0;
        early = 0;
        rdy   = 1'b1;
        st[sel] = 1'b1;
        @(posedge clk);
        n = 1;
        @(negedge clk);
        st[sel] = 1'b0;
        chk("first_valid", 64'(m_valid), 64'd1);
        chk("first_idx", 64'(m_idx), 64'd0);
        while (!m_done && n < 3000) begin
            if (m_valid) vcnt++;
            if (!m_busy) early++;
            if (rnd) rdy = 1'($urandom_range(0, 1));
            if (poke) begin
                st[sel] = (n % 5 == 2);
                key_a   = KALT;
            end
            @(posedge clk);
            n++;
            @(negedge clk);
        end
        st[sel] = 1'b0;
        rdy     = 1'b1;
        if (poke) key_a = K128;
        chk("done_seen", 64'(m_done), 64'd1);
        edges = n;
    endtask

    initial begin
        int edges, vcnt, early, x0, d0, v0, mism, n;
        rst = 1'b1; st = 3'b000; rdy = 1'b0; sel = 2'd0; key_a = K128;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_valid", 64'(ifa.word_valid), 64'd0);
        chk("rst_out", 64'(ifa.word_out), 64'd0);
        chk("rst_idx", 64'(ifa.word_idx), 64'd0);
        chk("rst_busy", 64'(ifa.busy), 64'd0);
        chk("rst_done", 64'(ifa.done), 64'd0);
        chk("rst_valid192", 64'(ifb.word_valid), 64'd0);
        chk("rst_busy256", 64'(ifc.busy), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // AES-128, ready held high
        x0 = nxf; d0 = ndone;
        run(1'b0, 1'b0, edges, vcnt, early);
        chk("k128_done_cycle", 64'(edges), 64'd45);
        chk("k128_words", 64'(nxf - x0), 64'd44);
        chk("k128_valid_cont", 64'(vcnt), 64'd44);
        chk("k128_busy_early", 64'(early), 64'd0);
        chk("k128_w0", 64'(lg[0]), 64'h2b7e1516);
        chk("k128_w3", 64'(lg[3]), 64'h09cf4f3c);
        chk("k128_w4", 64'(lg[4]), 64'ha0fafe17);
        chk("k128_w5", 64'(lg[5]), 64'h88542cb1);
        chk("k128_w6", 64'(lg[6]), 64'h23a33939);
        chk("k128_w7", 64'(lg[7]), 64'h2a6c7605);
        chk("k128_w40", 64'(lg[40]), 64'hd014f9a8);
        chk("k128_w43", 64'(lg[43]), 64'hb6630ca6);
        @(posedge clk);
        @(negedge clk);
        chk("k128_done_1cyc", 64'(m_done), 64'd0);
        chk("k128_done_count", 64'(ndone - d0), 64'd1);
        chk("k128_valid_after", 64'(m_valid), 64'd0);
        for (int i = 0; i < 44; i++) ref_lg[i] = lg[i];

        // AES-192
        sel = 2'd1;
        #1;
        x0 = nxf;
        run(1'b0, 1'b0, edges, vcnt, early);
        chk("k192_done_cycle", 64'(edges), 64'd53);
        chk("k192_words", 64'(nxf - x0), 64'd52);
        chk("k192_w0", 64'(lg[0]), 64'h8e73b0f7);
        chk("k192_w5", 64'(lg[5]), 64'h522c6b7b);
        chk("k192_w6", 64'(lg[6]), 64'hfe0c91f7);
        chk("k192_w7", 64'(lg[7]), 64'h2402f5a5);
        chk("k192_w51", 64'(lg[51]), 64'h01002202);
        @(negedge clk);

        // AES-256
        sel = 2'd2;
        #1;
        x0 = nxf;
        run(1'b0, 1'b0, edges, vcnt, early);
        chk("k256_done_cycle", 64'(edges), 64'd61);
        chk("k256_words", 64'(nxf - x0), 64'd60);
        chk("k256_w0", 64'(lg[0]), 64'h603deb10);
        chk("k256_w7", 64'(lg[7]), 64'h0914dff4);
        chk("k256_w8", 64'(lg[8]), 64'h9ba35411);
        chk("k256_w9", 64'(lg[9]), 64'h8e6925af);
        chk("k256_w12_subword", 64'(lg[12]), 64'ha8b09c1a);
        chk("k256_w59", 64'(lg[59]), 64'h706c631e);
        @(negedge clk);

        // AES-128 with random backpressure
        sel = 2'd0;
        #1;
        x0 = nxf; d0 = ndone; v0 = viol;
        run(1'b1, 1'b0, edges, vcnt, early);
        @(posedge clk);
        @(negedge clk);
        mism = 0;
        for (int i = 0; i < 44; i++) if (lg[i] !== ref_lg[i]) mism++;
        chk("rnd_seq_mism", 64'(mism), 64'd0);
        chk("rnd_w43", 64'(lg[43]), 64'hb6630ca6);
        chk("rnd_words", 64'(nxf - x0), 64'd44);
        chk("rnd_hold_viol", 64'(viol - v0), 64'd0);
        chk("rnd_done_count", 64'(ndone - d0), 64'd1);
        chk("rnd_busy_early", 64'(early), 64'd0);

        // Reset at word_idx 20, then restart
        rdy = 1'b1;
        st[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        st[0] = 1'b0;
        n = 0;
        while (m_idx != 6'd20 && n < 200) begin
            @(posedge clk);
            @(negedge clk);
            n++;
        end
        chk("mid_reached_idx20", 64'(m_idx), 64'd20);
        d0 = ndone;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("mid_rst_valid", 64'(m_valid), 64'd0);
        chk("mid_rst_out", 64'(m_out), 64'd0);
        chk("mid_rst_idx", 64'(m_idx), 64'd0);
        chk("mid_rst_busy", 64'(m_busy), 64'd0);
        chk("mid_rst_done", 64'(m_done), 64'd0);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("mid_no_done", 64'(ndone - d0), 64'd0);
        x0 = nxf;
        run(1'b0, 1'b0, edges, vcnt, early);
        mism = 0;
        for (int i = 0; i < 44; i++) if (lg[i] !== ref_lg[i]) mism++;
        chk("restart_seq_mism", 64'(mism), 64'd0);
        chk("restart_w4_rc01", 64'(lg[4]), 64'ha0fafe17);
        chk("restart_w43", 64'(lg[43]), 64'hb6630ca6);
        chk("restart_done_cycle", 64'(edges), 64'd45);
        @(negedge clk);

        // start pulsed while busy with a different key
        x0 = nxf;
        run(1'b0, 1'b1, edges, vcnt, early);
        mism = 0;
        for (int i = 0; i < 44; i++) if (lg[i] !== ref_lg[i]) mism++;
        chk("busy_start_seq_mism", 64'(mism), 64'd0);
        chk("busy_start_w43", 64'(lg[43]), 64'hb6630ca6);
        chk("busy_start_words", 64'(nxf - x0), 64'd44);
        chk("busy_start_early", 64'(early), 64'd0);
        chk("busy_start_done_cycle", 64'(edges), 64'd45);

        // start during the done cycle is ignored, accepted one cycle later
        st[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("start_in_done_valid", 64'(m_valid), 64'd0);
        chk("start_in_done_busy", 64'(m_busy), 64'd0);
        @(posedge clk);
        @(negedge clk);
        st[0] = 1'b0;
        chk("start_after_done_valid", 64'(m_valid), 64'd1);
        chk("start_after_done_w0", 64'(m_out), 64'h2b7e1516);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
